// File: rtl/pong_game_ctrl_if.sv
// Ball-block control bundle shared by the Pong game controller and the ball
// datapath. The controller (master) receives the frame pacing tick and the
// miss events, and it drives the reload, run and serve-direction controls.
interface pong_game_ctrl_if;
   logic frame_tick;   // one-cycle pulse at end of each frame
   logic miss_left;    // ball passed the left boundary
   logic miss_right;   // ball passed the right boundary
   logic ball_load;    // reload ball to centre
   logic ball_run;     // ball may advance on frame_tick
   logic serve_dir;    // 0 = toward left, 1 = toward right

   modport master (
      input  frame_tick,
      input  miss_left,
      input  miss_right,
      output ball_load,
      output ball_run,
      output serve_dir
   );

   modport slave (
      output frame_tick,
      output miss_left,
      output miss_right,
      input  ball_load,
      input  ball_run,
      input  serve_dir
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: IDLE -> SERVE -> PLAY -> POINT/GAMEOVER.
// Keeps both scores, paces serve and point delays in frames using
// frame_tick, and drives the ball block through pong_game_ctrl_if.
// Optional demo mode: define PONG_ATTRACT_EN to keep the ball running in
// IDLE. Misses in IDLE then reload the ball and flip the serve direction.
// All outputs come straight from registers.
module pong_game_ctrl #(
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int WIN_SCORE    = 7,
   parameter int SCORE_W      = 4,
   parameter int CNT_W        = 8
) (
   input  logic               clk25M,
   input  logic               reset_n,
   input  logic               start_btn,
   pong_game_ctrl_if.master   bus,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               game_over,
   output logic               winner,
   output logic [2:0]         state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SERVE    = 3'd1,
      S_PLAY     = 3'd2,
      S_POINT    = 3'd3,
      S_GAMEOVER = 3'd4
   } state_t;

   localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   SERVE_LD = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0]   POINT_LD = CNT_W'(POINT_FRAMES - 1);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [SCORE_W-1:0] score_l_reg, score_l_next;
   logic [SCORE_W-1:0] score_r_reg, score_r_next;
   logic               serve_dir_reg, serve_dir_next;
   logic               ball_load_reg, ball_load_next;
   logic               ball_run_reg, ball_run_next;
   logic               game_over_reg, game_over_next;
   logic               winner_reg, winner_next;
   logic               start_prev_reg;

   logic               start_edge;
   logic [SCORE_W-1:0] score_l_inc;
   logic [SCORE_W-1:0] score_r_inc;

   // The previous button value resets to 1, so a button held through reset
   // must be released and pressed again before it counts as a start.
   assign start_edge = start_btn & ~start_prev_reg;

   // Saturating increments: a score never moves past the winning value.
   assign score_l_inc = (score_l_reg >= WIN) ? score_l_reg : score_l_reg + 1'b1;
   assign score_r_inc = (score_r_reg >= WIN) ? score_r_reg : score_r_reg + 1'b1;

   // State and output registers.
   always_ff @(posedge clk25M or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= S_IDLE;
         cnt_reg        <= '0;
         score_l_reg    <= '0;
         score_r_reg    <= '0;
         serve_dir_reg  <= 1'b0;
         ball_load_reg  <= 1'b0;
         ball_run_reg   <= 1'b0;
         game_over_reg  <= 1'b0;
         winner_reg     <= 1'b0;
         start_prev_reg <= 1'b1;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         score_l_reg    <= score_l_next;
         score_r_reg    <= score_r_next;
         serve_dir_reg  <= serve_dir_next;
         ball_load_reg  <= ball_load_next;
         ball_run_reg   <= ball_run_next;
         game_over_reg  <= game_over_next;
         winner_reg     <= winner_next;
         start_prev_reg <= start_btn;
      end
   end

   // Next-state logic. Output values are decoded from the next state so the
   // registered outputs line up with the state they belong to.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      score_l_next   = score_l_reg;
      score_r_next   = score_r_reg;
      serve_dir_next = serve_dir_reg;
      winner_next    = winner_reg;
      ball_load_next = 1'b0;

      case (state_reg)
         S_IDLE, S_GAMEOVER: begin
            if (start_edge) begin
               score_l_next   = '0;
               score_r_next   = '0;
               serve_dir_next = 1'b0;
               ball_load_next = 1'b1;
               cnt_next       = SERVE_LD;
               state_next     = S_SERVE;
            end
`ifdef PONG_ATTRACT_EN
            else if ((state_reg == S_IDLE) && (bus.miss_left || bus.miss_right)) begin
               // Demo mode: re-serve from centre in the opposite direction.
               ball_load_next = 1'b1;
               serve_dir_next = ~serve_dir_reg;
            end
`endif
         end

         S_SERVE: begin
            if (bus.frame_tick) begin
               if (cnt_reg == '0) begin
                  state_next = S_PLAY;
               end else begin
                  cnt_next = cnt_reg - 1'b1;
               end
            end
         end

         S_PLAY: begin
            // Misses take priority; frame_tick is not counted in PLAY at all,
            // so a coincident tick never shortens the following pause.
            if (bus.miss_left && bus.miss_right) begin
               cnt_next   = POINT_LD;
               state_next = S_POINT;
            end else if (bus.miss_left) begin
               score_r_next   = score_r_inc;
               serve_dir_next = 1'b0;
               if (score_r_inc == WIN) begin
                  winner_next = 1'b1;
                  state_next  = S_GAMEOVER;
               end else begin
                  cnt_next   = POINT_LD;
                  state_next = S_POINT;
               end
            end else if (bus.miss_right) begin
               score_l_next   = score_l_inc;
               serve_dir_next = 1'b1;
               if (score_l_inc == WIN) begin
                  winner_next = 1'b0;
                  state_next  = S_GAMEOVER;
               end else begin
                  cnt_next   = POINT_LD;
                  state_next = S_POINT;
               end
            end
         end

         S_POINT: begin
            if (bus.frame_tick) begin
               if (cnt_reg == '0) begin
                  ball_load_next = 1'b1;
                  cnt_next       = SERVE_LD;
                  state_next     = S_SERVE;
               end else begin
                  cnt_next = cnt_reg - 1'b1;
               end
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

`ifdef PONG_ATTRACT_EN
      ball_run_next  = (state_next == S_PLAY) || (state_next == S_IDLE);
`else
      ball_run_next  = (state_next == S_PLAY);
`endif
      game_over_next = (state_next == S_GAMEOVER);
   end

   assign bus.ball_load = ball_load_reg;
   assign bus.ball_run  = ball_run_reg;
   assign bus.serve_dir = serve_dir_reg;
   assign score_l       = score_l_reg;
   assign score_r       = score_r_reg;
   assign game_over     = game_over_reg;
   assign winner        = winner_reg;
   assign state_dbg     = state_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with default parameters
// (60 serve frames, 90 point frames, first to 7).
module tb_pong_game_ctrl;

   logic       clk25M;
   logic       reset_n;
   logic       start_btn;
   logic [3:0] score_l;
   logic [3:0] score_r;
   logic       game_over;
   logic       winner;
   logic [2:0] state_dbg;

   int n_pass;
   int n_total;
   int load_cnt;

   pong_game_ctrl_if bus ();

   pong_game_ctrl dut (
      .clk25M    (clk25M),
      .reset_n   (reset_n),
      .start_btn (start_btn),
      .bus       (bus),
      .score_l   (score_l),
      .score_r   (score_r),
      .game_over (game_over),
      .winner    (winner),
      .state_dbg (state_dbg)
   );

   initial clk25M = 1'b0;
   always #5 clk25M = ~clk25M;

   // Count ball_load pulses, sampled away from the active edge.
   always @(negedge clk25M) begin
      if (bus.ball_load === 1'b1) load_cnt++;
   end

   task automatic step();
      @(posedge clk25M);
      #1;
   endtask

   task automatic pulse_tick();
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) pulse_tick();
   endtask

   task automatic press_start();
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      step();
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) $display("FAIL %s: got %0d want %0d", name, got, want);
      else begin
         n_pass++;
         $display("check %s: %0d ok", name, got);
      end
   endtask

   task automatic test_reset();
      logic exp_idle_run;
`ifdef PONG_ATTRACT_EN
      exp_idle_run = 1'b1;
`else
      exp_idle_run = 1'b0;
`endif
      reset_n = 1'b0;
      start_btn = 1'b1;
      repeat (3) step();
      chk("rst_state", state_dbg, 0);
      chk("rst_scores", {score_l, score_r}, 0);
      chk("rst_outs", {bus.ball_load, bus.ball_run, bus.serve_dir, game_over, winner}, 0);
      reset_n = 1'b1;
      repeat (4) step();
      chk("held_btn_no_start", state_dbg, 0);
      chk("held_btn_no_load", load_cnt, 0);
      start_btn = 1'b0;
      step();
      // A miss in IDLE must not score.
      bus.miss_left = 1'b1;
      step();
      bus.miss_left = 1'b0;
      step();
      chk("idle_miss_no_score", score_r, 0);
      chk("idle_ball_run", bus.ball_run, exp_idle_run);
   endtask

   task automatic test_serve();
      int l0;
      l0 = load_cnt;
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      chk("start_load_pulse", bus.ball_load, 1);
      chk("start_state", state_dbg, 1);
      step();
      chk("load_one_cycle", bus.ball_load, 0);
      chk("load_count", load_cnt - l0, 1);
      // Start edge during SERVE is ignored.
      press_start();
      chk("serve_restart_ignored", load_cnt - l0, 1);
      ticks(59);
      chk("serve_59_state", state_dbg, 1);
      chk("serve_59_run", bus.ball_run, 0);
      pulse_tick();
      chk("serve_60_state", state_dbg, 2);
      chk("serve_60_run", bus.ball_run, 1);
   endtask

   task automatic test_point();
      bus.miss_left = 1'b1;
      step();
      bus.miss_left = 1'b0;
      chk("ml_score_r", score_r, 1);
      chk("ml_score_l", score_l, 0);
      chk("ml_dir", bus.serve_dir, 0);
      chk("ml_state", state_dbg, 3);
      chk("ml_run_drop", bus.ball_run, 0);
      ticks(89);
      chk("point_89_state", state_dbg, 3);
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      chk("point_exp_state", state_dbg, 1);
      chk("point_exp_load", bus.ball_load, 1);
      step();
      chk("point_load_drop", bus.ball_load, 0);
      ticks(60);
      chk("replay_state", state_dbg, 2);
   endtask

   task automatic test_tick_miss();
      bus.frame_tick = 1'b1;
      bus.miss_right = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      bus.miss_right = 1'b0;
      step();
      chk("tm_score_l", score_l, 1);
      chk("tm_dir", bus.serve_dir, 1);
      chk("tm_state", state_dbg, 3);
      ticks(89);
      chk("tm_89_state", state_dbg, 3);
      pulse_tick();
      chk("tm_90_state", state_dbg, 1);
      ticks(60);
      chk("tm_play", state_dbg, 2);
   endtask

   task automatic test_double_miss();
      bus.miss_left = 1'b1;
      bus.miss_right = 1'b1;
      step();
      bus.miss_left = 1'b0;
      bus.miss_right = 1'b0;
      chk("dm_scores", {score_l, score_r}, {4'd1, 4'd1});
      chk("dm_dir", bus.serve_dir, 1);
      chk("dm_state", state_dbg, 3);
   endtask

   task automatic test_async_reset();
      ticks(90);
      chk("ar_in_serve", state_dbg, 1);
      ticks(29);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_state_now", state_dbg, 0);
      chk("ar_scores_now", {score_l, score_r}, 0);
      chk("ar_outs_now", {bus.ball_load, bus.ball_run, bus.serve_dir, game_over, winner}, 0);
      step();
      reset_n = 1'b1;
      step();
      step();
   endtask

   task automatic test_win();
      press_start();
      ticks(60);
      chk("win_play", state_dbg, 2);
      for (int i = 0; i < 7; i++) begin
         bus.miss_right = 1'b1;
         step();
         bus.miss_right = 1'b0;
         step();
         if (i < 6) begin
            chk("win_point_state", state_dbg, 3);
            ticks(150);
         end
      end
      chk("win_score_l", score_l, 7);
      chk("win_score_r", score_r, 0);
      chk("win_game_over", game_over, 1);
      chk("win_winner", winner, 0);
      chk("win_state", state_dbg, 4);
      chk("win_run", bus.ball_run, 0);
      bus.miss_right = 1'b1;
      step();
      bus.miss_right = 1'b0;
      bus.miss_left = 1'b1;
      step();
      bus.miss_left = 1'b0;
      step();
      chk("frozen_scores", {score_l, score_r}, {4'd7, 4'd0});
      press_start();
      chk("restart_state", state_dbg, 1);
      chk("restart_scores", {score_l, score_r}, 0);
      chk("restart_game_over", game_over, 0);
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      load_cnt = 0;
      bus.frame_tick = 1'b0;
      bus.miss_left = 1'b0;
      bus.miss_right = 1'b0;
      test_reset();
      test_serve();
      test_point();
      test_tick_miss();
      test_double_miss();
      test_async_reset();
      test_win();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the Pong datapath. It owns the match state machine (idle, serve, play, point pause, game over) and drives the ball block's load/run controls. It receives miss events from the ball block, keeps both scores, and paces every delay in video frames using the end-of-frame tick. It sits between the ball/paddle datapath and the score display/VGA mux.

Parameters:
SERVE_FRAMES, 60, frames the ball is held at centre before release
POINT_FRAMES, 90, frames of pause after a point is scored
WIN_SCORE, 7, score that ends the match
SCORE_W, 4, width of each score counter (must hold WIN_SCORE)
CNT_W, 8, width of the frame countdown counter (must hold max(SERVE_FRAMES, POINT_FRAMES))

Ports:
clk25M  in  1  25 MHz pixel clock; the only clock
reset_n  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse at end of each frame
start_btn  in  1  synchronised start button, level
miss_left  in  1  one-cycle pulse: ball passed the left boundary
miss_right  in  1  one-cycle pulse: ball passed the right boundary
ball_load  out  1  one-cycle pulse: ball block reloads to centre
ball_run  out  1  ball block may advance on frame_tick
serve_dir  out  1  0 = serve toward left, 1 = serve toward right
score_l  out  SCORE_W  left player score
score_r  out  SCORE_W  right player score
game_over  out  1  high in GAMEOVER
winner  out  1  0 = left won, 1 = right won; valid while game_over is high
state_dbg  out  3  current state encoding

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, scores 0, counter 0, ball_load 0, ball_run 0, serve_dir 0, game_over 0, winner 0.
- start_btn is rising-edge detected internally with a registered previous value, reset to 1 so that a button held through reset does not start a match.
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
- IDLE: on start edge, clear scores, set serve_dir=0, pulse ball_load, load counter=SERVE_FRAMES-1, enter SERVE on the next cycle.
- SERVE: ball_run=0. Each frame_tick decrements the counter. A frame_tick while the counter is 0 enters PLAY. Total hold is exactly SERVE_FRAMES ticks.
- PLAY: ball_run=1.
  - miss_left: score_r+1, serve_dir=0 (toward the player who lost the point).
  - miss_right: score_l+1, serve_dir=1.
  - After either miss: if the new score equals WIN_SCORE, enter GAMEOVER with winner set accordingly. Otherwise enter POINT with counter=POINT_FRAMES-1.
  - ball_run drops in the cycle after the miss.
  - miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, enter POINT.
- POINT: ball_run=0; frame_tick counts down as in SERVE. On expiry, pulse ball_load, load counter=SERVE_FRAMES-1, enter SERVE.
- GAMEOVER: game_over=1, ball_run=0, scores frozen. A start edge behaves exactly as in IDLE, starting a new match.
- Miss pulses outside PLAY are ignored. start_btn edges outside IDLE/GAMEOVER are ignored.
- A frame_tick coinciding with a miss: the miss takes priority and the tick is not counted.
- ball_load is registered: exactly one cycle wide, asserted on the cycle of entry into SERVE.
- Scores saturate at WIN_SCORE and never wrap.
- All outputs are registered.

Optional Feature:
PONG_ATTRACT_EN
- Defined: IDLE keeps ball_run=1 (demo mode). Misses in IDLE pulse ball_load and set serve_dir = NOT serve_dir. Scores are not changed. A start edge behaves as normal.
- Undefined: ball_run=0 in IDLE and misses are ignored, exactly as specified above.

Test Plan:
- Reset with start_btn held high, then release and press -> exactly one ball_load pulse; state SERVE; ball_run goes high after exactly 60 frame_ticks.
- PLAY, miss_left pulse -> score_r 0->1, serve_dir=0, state POINT; after 90 ticks, ball_load pulses and state is SERVE.
- Seven miss_right events across points -> score_l=7, game_over=1, winner=0; further misses leave scores at 7/0.
- miss_left and miss_right in the same cycle during PLAY -> scores unchanged, state POINT, serve_dir unchanged.
- reset_n asserted mid-SERVE with counter=30 -> all outputs go to reset values immediately, without waiting for a clock edge; state IDLE.
- frame_tick coincident with miss_right in PLAY -> score_l+1; the POINT counter starts at 89 and is not decremented by that tick.
